// File: rtl/ysyx_22040000_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040000_lsu_pkg
// Brief    : Shared load/store type codes, widths and LSU state encoding.
// Revision : 1.0  initial release
// ============================================================================
package ysyx_22040000_lsu_pkg;

    localparam int LSU_DWIDTH     = 32;
    localparam int LSU_MASK_WIDTH = LSU_DWIDTH / 8;

    localparam int LD_TYPE_W  = 3;
    localparam int STR_TYPE_W = 2;

    // Load type codes follow the RISC-V funct3 field
    localparam logic [LD_TYPE_W-1:0] LD_TYPE_LB  = 3'b000;
    localparam logic [LD_TYPE_W-1:0] LD_TYPE_LH  = 3'b001;
    localparam logic [LD_TYPE_W-1:0] LD_TYPE_LW  = 3'b010;
    localparam logic [LD_TYPE_W-1:0] LD_TYPE_LBU = 3'b100;
    localparam logic [LD_TYPE_W-1:0] LD_TYPE_LHU = 3'b101;

    localparam logic [STR_TYPE_W-1:0] STR_TYPE_SB = 2'b00;
    localparam logic [STR_TYPE_W-1:0] STR_TYPE_SH = 2'b01;
    localparam logic [STR_TYPE_W-1:0] STR_TYPE_SW = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE     = 2'd0,
        LSU_REQ      = 2'd1,
        LSU_WAIT_RSP = 2'd2,
        LSU_DONE     = 2'd3
    } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/ysyx_22040000_lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040000_lsu_align
// Brief    : Combinational store lane steering, load extract/extend and
//            misalignment / illegal-op detection.
// Revision : 1.0  initial release
// ============================================================================
module ysyx_22040000_lsu_align
    import ysyx_22040000_lsu_pkg::*;
(
    input  logic                      i_ld,
    input  logic                      i_st,
    input  logic [LD_TYPE_W-1:0]      i_ld_type,
    input  logic [STR_TYPE_W-1:0]     i_str_type,
    input  logic [1:0]                i_addr_lo,
    input  logic [LSU_DWIDTH-1:0]     i_wdata,
    input  logic [LSU_DWIDTH-1:0]     i_rdata,
    output logic                      o_err,
    output logic [LSU_MASK_WIDTH-1:0] o_wmask,
    output logic [LSU_DWIDTH-1:0]     o_wdata,
    output logic [LSU_DWIDTH-1:0]     o_rdata
);

    logic [LSU_DWIDTH-1:0]     w_shift;
    logic [LSU_DWIDTH-1:0]     w_ld_ext;
    logic                      w_ld_bad;
    logic                      w_ld_mis;
    logic [LSU_MASK_WIDTH-1:0] w_st_mask;
    logic [LSU_DWIDTH-1:0]     w_st_data;
    logic                      w_st_bad;
    logic                      w_st_mis;
    logic                      w_err;

    // Load path: bring the addressed byte/half to bit 0, then extend
    always_comb begin
        w_shift  = i_rdata >> {i_addr_lo, 3'b000};
        w_ld_ext = '0;
        w_ld_bad = 1'b0;
        w_ld_mis = 1'b0;
        case (i_ld_type)
            LD_TYPE_LB:  w_ld_ext = {{24{w_shift[7]}}, w_shift[7:0]};
            LD_TYPE_LBU: w_ld_ext = {24'd0, w_shift[7:0]};
            LD_TYPE_LH: begin
                w_ld_ext = {{16{w_shift[15]}}, w_shift[15:0]};
                w_ld_mis = i_addr_lo[0];
            end
            LD_TYPE_LHU: begin
                w_ld_ext = {16'd0, w_shift[15:0]};
                w_ld_mis = i_addr_lo[0];
            end
            LD_TYPE_LW: begin
                w_ld_ext = w_shift;
                w_ld_mis = |i_addr_lo;
            end
            default:     w_ld_bad = 1'b1;
        endcase
    end

    // Store path: byte enables shifted to the lane, data replicated across lanes
    always_comb begin
        w_st_mask = '0;
        w_st_data = '0;
        w_st_bad  = 1'b0;
        w_st_mis  = 1'b0;
        case (i_str_type)
            STR_TYPE_SB: begin
                w_st_mask = 4'b0001 << i_addr_lo;
                w_st_data = {4{i_wdata[7:0]}};
            end
            STR_TYPE_SH: begin
                w_st_mask = 4'b0011 << i_addr_lo;
                w_st_data = {2{i_wdata[15:0]}};
                w_st_mis  = i_addr_lo[0];
            end
            STR_TYPE_SW: begin
                w_st_mask = 4'b1111;
                w_st_data = i_wdata;
                w_st_mis  = |i_addr_lo;
            end
            default:     w_st_bad = 1'b1;
        endcase
    end

    // Error qualification and output gating; errored ops never expose data
    always_comb begin
        w_err   = (i_ld & i_st)
                | (i_ld & (w_ld_bad | w_ld_mis))
                | (i_st & (w_st_bad | w_st_mis));
        o_err   = w_err;
        o_wmask = (i_st & ~w_err) ? w_st_mask : '0;
        o_wdata = (i_st & ~w_err) ? w_st_data : '0;
        o_rdata = (i_ld & ~w_err) ? w_ld_ext  : '0;
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_22040000_lsu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040000_lsu
// Brief    : Load/store unit. Latches one EXU request, issues a single memory
//            transaction over valid/ready, returns the aligned result.
// Revision : 1.0  initial release
// ============================================================================
module ysyx_22040000_lsu
    import ysyx_22040000_lsu_pkg::*;
#(
    parameter int DWIDTH     = LSU_DWIDTH,
    parameter int MASK_WIDTH = LSU_MASK_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_ld,
    input  logic                  in_st,
    input  logic [LD_TYPE_W-1:0]  in_ld_type,
    input  logic [STR_TYPE_W-1:0] in_str_type,
    input  logic [DWIDTH-1:0]     in_addr,
    input  logic [DWIDTH-1:0]     in_wdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [DWIDTH-1:0]     mem_addr,
    output logic                  mem_wen,
    output logic [MASK_WIDTH-1:0] mem_wmask,
    output logic [DWIDTH-1:0]     mem_wdata,
    input  logic                  mem_rsp_valid,
    input  logic [DWIDTH-1:0]     mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DWIDTH-1:0]     out_rdata,
    output logic                  out_err
);

    lsu_state_e              state_q, state_d;
    logic                    ld_q, ld_d;
    logic                    st_q, st_d;
    logic [LD_TYPE_W-1:0]    ld_type_q, ld_type_d;
    logic [STR_TYPE_W-1:0]   str_type_q, str_type_d;
    logic [DWIDTH-1:0]       addr_q, addr_d;
    logic [DWIDTH-1:0]       wdata_q, wdata_d;
    logic [DWIDTH-1:0]       rdata_q, rdata_d;

    logic                    w_accept;
    logic                    w_sel_ld;
    logic                    w_sel_st;
    logic [LD_TYPE_W-1:0]    w_sel_ld_type;
    logic [STR_TYPE_W-1:0]   w_sel_str_type;
    logic [1:0]              w_sel_addr_lo;
    logic [DWIDTH-1:0]       w_sel_wdata;
    logic                    w_err;
    logic [MASK_WIDTH-1:0]   w_wmask;
    logic [DWIDTH-1:0]       w_wdata;
    logic [DWIDTH-1:0]       w_rdata;

    assign w_accept = in_valid & (state_q == LSU_IDLE);

    // In IDLE the checker looks at the live request so the legality decision is
    // ready at accept time; afterwards it works on the latched copy.
    always_comb begin
        if (state_q == LSU_IDLE) begin
            w_sel_ld       = in_ld;
            w_sel_st       = in_st;
            w_sel_ld_type  = in_ld_type;
            w_sel_str_type = in_str_type;
            w_sel_addr_lo  = in_addr[1:0];
            w_sel_wdata    = in_wdata;
        end else begin
            w_sel_ld       = ld_q;
            w_sel_st       = st_q;
            w_sel_ld_type  = ld_type_q;
            w_sel_str_type = str_type_q;
            w_sel_addr_lo  = addr_q[1:0];
            w_sel_wdata    = wdata_q;
        end
    end

    ysyx_22040000_lsu_align u_align (
        .i_ld       (w_sel_ld),
        .i_st       (w_sel_st),
        .i_ld_type  (w_sel_ld_type),
        .i_str_type (w_sel_str_type),
        .i_addr_lo  (w_sel_addr_lo),
        .i_wdata    (w_sel_wdata),
        .i_rdata    (rdata_q),
        .o_err      (w_err),
        .o_wmask    (w_wmask),
        .o_wdata    (w_wdata),
        .o_rdata    (w_rdata)
    );

    // Request latch on accept; response word captured only while waiting for it
    always_comb begin
        ld_d       = ld_q;
        st_d       = st_q;
        ld_type_d  = ld_type_q;
        str_type_d = str_type_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        if (w_accept) begin
            ld_d       = in_ld;
            st_d       = in_st;
            ld_type_d  = in_ld_type;
            str_type_d = in_str_type;
            addr_d     = in_addr;
            wdata_d    = in_wdata;
        end
        if ((state_q == LSU_WAIT_RSP) && mem_rsp_valid) begin
            rdata_d = mem_rdata;
        end
    end

    // Next-state: errors and no-op requests skip memory and go straight to DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE: begin
                if (in_valid) begin
                    if (w_err || (!in_ld && !in_st)) begin
                        state_d = LSU_DONE;
                    end else begin
                        state_d = LSU_REQ;
                    end
                end
            end
            LSU_REQ:      if (mem_req_ready) state_d = LSU_WAIT_RSP;
            LSU_WAIT_RSP: if (mem_rsp_valid) state_d = LSU_DONE;
            LSU_DONE:     if (out_ready)     state_d = LSU_IDLE;
            default:                         state_d = LSU_IDLE;
        endcase
    end

    // Outputs decoded from state; everything idles at zero outside its phase
    always_comb begin
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        mem_addr      = '0;
        mem_wen       = 1'b0;
        mem_wmask     = '0;
        mem_wdata     = '0;
        out_valid     = 1'b0;
        out_rdata     = '0;
        out_err       = 1'b0;
        case (state_q)
            LSU_IDLE: in_ready = 1'b1;
            LSU_REQ: begin
                mem_req_valid = 1'b1;
                mem_addr      = {addr_q[DWIDTH-1:2], 2'b00};
                mem_wen       = st_q;
                mem_wmask     = w_wmask;
                mem_wdata     = w_wdata;
            end
            LSU_DONE: begin
                out_valid = 1'b1;
                out_err   = w_err;
                out_rdata = w_rdata;
            end
            default: ;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LSU_IDLE;
            ld_q       <= 1'b0;
            st_q       <= 1'b0;
            ld_type_q  <= '0;
            str_type_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            ld_q       <= ld_d;
            st_q       <= st_d;
            ld_type_q  <= ld_type_d;
            str_type_q <= str_type_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040000_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22040000_lsu
// Brief    : Self-checking bench for the LSU with a behavioural memory and
//            a byte-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_22040000_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_ld, in_st;
    logic [2:0]  in_ld_type;
    logic [1:0]  in_str_type;
    logic [31:0] in_addr, in_wdata;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_rdata;

    always #5 clk = ~clk;

    ysyx_22040000_lsu dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_ld(in_ld), .in_st(in_st),
        .in_ld_type(in_ld_type), .in_str_type(in_str_type),
        .in_addr(in_addr), .in_wdata(in_wdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rdata(out_rdata), .out_err(out_err)
    );

    int checks = 0;
    int failures = 0;

    // Expectation of the transaction in flight
    logic        exp_pending = 0, exp_access = 0, exp_err = 0, exp_ld = 0, exp_wen = 0;
    logic [2:0]  exp_lt = 0;
    logic [31:0] exp_byte_addr = 0, exp_addr = 0, exp_wdata = 0;
    logic [3:0]  exp_wmask = 0;
    logic [31:0] rsp_word = 0;

    // Memory behaviour knobs
    int          cfg_rdly = 0, cfg_rsdly = 0;
    logic        cfg_fixed_en = 0;
    logic [31:0] cfg_fixed = 0;

    // Observations for the literal pins
    int          req_cnt = 0;
    logic [31:0] last_addr = 0, last_wdata = 0, last_rdata = 0;
    logic [3:0]  last_wmask = 0;
    logic        last_wen = 0, last_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Access size in bytes; 0 means the type code is not defined
    function automatic int op_size(input logic ld, input logic [2:0] lt, input logic [1:0] stt);
        if (ld) begin
            if (lt == 3'd0 || lt == 3'd4) return 1;
            if (lt == 3'd1 || lt == 3'd5) return 2;
            if (lt == 3'd2) return 4;
            return 0;
        end
        if (stt == 2'd0) return 1;
        if (stt == 2'd1) return 2;
        if (stt == 2'd2) return 4;
        return 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] lt, input logic [31:0] addr,
                                                input logic [31:0] word);
        int     sz;
        longint v;
        sz = op_size(1'b1, lt, 2'd0);
        v  = (longint'(word) >> (8 * (addr % 4))) & ((64'd1 << (8 * sz)) - 1);
        if (!(lt == 3'd4 || lt == 3'd5) && sz < 4 && v >= (64'd1 << (8 * sz - 1)))
            v = v - (64'd1 << (8 * sz));
        return v[31:0];
    endfunction

    task automatic set_expect(input logic ld, input logic st, input logic [2:0] lt,
                              input logic [1:0] stt, input logic [31:0] addr,
                              input logic [31:0] wd);
        int   sz;
        logic mis;
        sz  = op_size(ld, lt, stt);
        mis = (sz != 0) && ((addr % sz) != 0);
        exp_err       = (ld && st) || ((ld || st) && (sz == 0 || mis));
        exp_access    = (ld || st) && !exp_err;
        exp_ld        = ld;
        exp_lt        = lt;
        exp_wen       = st;
        exp_byte_addr = addr;
        exp_addr      = addr & 32'hFFFF_FFFC;
        exp_wmask     = 4'd0;
        exp_wdata     = 32'd0;
        if (st && exp_access) begin
            exp_wmask = 4'(((1 << sz) - 1) << (addr % 4));
            for (int i = 0; i < 4; i++)
                exp_wdata = exp_wdata | (((wd >> (8 * (i % sz))) & 32'hFF) << (8 * i));
        end
        exp_pending = 1'b1;
    endtask

    // Behavioural memory: optional ready stall, then response after a delay
    initial begin
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;
        forever begin
            mem_req_ready = 0; mem_rsp_valid = 0;
            @(posedge clk); #1;
            if (mem_req_valid) begin
                repeat (cfg_rdly) begin @(posedge clk); #1; end
                mem_req_ready = 1;
                @(posedge clk); #1;
                mem_req_ready = 0;
                repeat (cfg_rsdly) begin @(posedge clk); #1; end
                mem_rdata     = cfg_fixed_en ? cfg_fixed : $urandom;
                rsp_word      = mem_rdata;
                mem_rsp_valid = 1;
                @(posedge clk); #1;
                mem_rsp_valid = 0;
            end
        end
    end

    // Per-cycle comparison against the expectation of the transaction in flight
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req_valid) req_cnt++;
            if (exp_access) begin
                if (mem_req_valid) begin
                    chk("req_addr", mem_addr, exp_addr);
                    chk("req_wen", {31'd0, mem_wen}, {31'd0, exp_wen});
                    chk("req_wmask", {28'd0, mem_wmask}, {28'd0, exp_wmask});
                    if (exp_wen) chk("req_wdata", mem_wdata, exp_wdata);
                    last_addr = mem_addr; last_wen = mem_wen;
                    last_wmask = mem_wmask; last_wdata = mem_wdata;
                end
            end else begin
                chk("unexpected_req", {31'd0, mem_req_valid}, 32'd0);
            end
            if (exp_pending) begin
                if (out_valid) begin
                    chk("out_err", {31'd0, out_err}, {31'd0, exp_err});
                    chk("out_rdata", out_rdata,
                        (exp_access && exp_ld) ? model_load(exp_lt, exp_byte_addr, rsp_word) : 32'd0);
                    last_err = out_err; last_rdata = out_rdata;
                end
            end else begin
                chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
            end
        end
    end

    task automatic do_txn(input logic ld, input logic st, input logic [2:0] lt,
                          input logic [1:0] stt, input logic [31:0] addr,
                          input logic [31:0] wd, input int rdly, input int rsdly,
                          input int odly, output int lat);
        cfg_rdly = rdly; cfg_rsdly = rsdly;
        set_expect(ld, st, lt, stt, addr, wd);
        in_valid = 1; in_ld = ld; in_st = st; in_ld_type = lt;
        in_str_type = stt; in_addr = addr; in_wdata = wd;
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 0; in_ld = $urandom; in_st = $urandom; in_ld_type = $urandom;
        in_str_type = $urandom; in_addr = $urandom; in_wdata = $urandom;
        chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
        lat = 1;
        while (!out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
        chk("out_valid_arrives", {31'd0, out_valid}, 32'd1);
        if (out_valid) begin
            repeat (odly) begin @(posedge clk); #1; end
            out_ready = 1;
            @(posedge clk); #1;
            out_ready = 0;
        end
        exp_pending = 0; exp_access = 0;
        chk("in_ready_after", {31'd0, in_ready}, 32'd1);
        chk("out_valid_after", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, rc;
        logic ld, st;
        rst = 1; in_valid = 0; in_ld = 0; in_st = 0; in_ld_type = 0; in_str_type = 0;
        in_addr = 0; in_wdata = 0; out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_out_rdata", out_rdata, 32'd0);
        chk("rst_mem_bus", {mem_addr ^ mem_wdata, 27'd0, mem_wen, mem_wmask} |
                           {mem_addr, 32'd0} >> 32, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 0;
        @(posedge clk); #1;

        // SW, zero-wait memory
        do_txn(0, 1, 3'd0, 2'd2, 32'h8000_0004, 32'hDEAD_BEEF, 0, 0, 0, lat);
        chk("sw_latency", lat, 32'd3);
        chk("sw_wmask", {28'd0, last_wmask}, 32'hF);
        chk("sw_addr", last_addr, 32'h8000_0004);
        chk("sw_wdata", last_wdata, 32'hDEAD_BEEF);
        chk("sw_err", {31'd0, last_err}, 32'd0);

        // SB to the top lane
        do_txn(0, 1, 3'd0, 2'd0, 32'h8000_0003, 32'h0000_00A5, 0, 0, 0, lat);
        chk("sb_wmask", {28'd0, last_wmask}, 32'h8);
        chk("sb_wdata", last_wdata, 32'hA5A5_A5A5);
        chk("sb_wen", {31'd0, last_wen}, 32'd1);

        // LB / LBU from lane 2 of a fixed word
        cfg_fixed_en = 1; cfg_fixed = 32'h0080_0000;
        do_txn(1, 0, 3'd0, 2'd0, 32'h8000_0002, 32'd0, 0, 0, 0, lat);
        chk("lb_rdata", last_rdata, 32'hFFFF_FF80);
        do_txn(1, 0, 3'd4, 2'd0, 32'h8000_0002, 32'd0, 0, 0, 0, lat);
        chk("lbu_rdata", last_rdata, 32'h0000_0080);
        cfg_fixed_en = 0;

        // Misaligned LH never touches memory
        rc = req_cnt;
        do_txn(1, 0, 3'd1, 2'd0, 32'h8000_0001, 32'd0, 0, 0, 0, lat);
        chk("lh_mis_latency", lat, 32'd1);
        chk("lh_mis_err", {31'd0, last_err}, 32'd1);
        chk("lh_mis_rdata", last_rdata, 32'd0);
        chk("lh_mis_no_req", req_cnt, rc);

        // No-op request
        do_txn(0, 0, 3'd2, 2'd2, 32'h8000_0000, 32'h1234_5678, 0, 0, 0, lat);
        chk("nop_latency", lat, 32'd1);
        chk("nop_err", {31'd0, last_err}, 32'd0);

        // Back-pressure everywhere: fields must hold while stalled
        do_txn(1, 0, 3'd2, 2'd0, 32'h8000_0010, 32'd0, 3, 1, 2, lat);
        chk("slow_latency", lat, 32'd7);

        // Reset while waiting for a response; the late response must be ignored
        cfg_rdly = 0; cfg_rsdly = 3;
        set_expect(1, 0, 3'd2, 2'd0, 32'h8000_0020, 32'd0);
        in_valid = 1; in_ld = 1; in_st = 0; in_ld_type = 3'd2; in_addr = 32'h8000_0020;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        rst = 1; exp_pending = 0; exp_access = 0;
        @(posedge clk); #1;
        rst = 0;
        chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (8) begin
            chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
            @(posedge clk); #1;
        end

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 9);
            ld = (r <= 4); st = (r >= 5 && r <= 8);
            if (r == 9) begin ld = $urandom; st = ld; end
            do_txn(ld, st, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                   $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), lat);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
